// File: rtl/ps2_key_matrix.sv
// rtl/ps2_key_matrix.sv - PS/2 key events to a scanned N x M key matrix via a loadable map
module ps2_key_matrix #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RB   = $clog2(ROWS),
  parameter int CB   = $clog2(COLS)
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [10:0]           ps2_key,
  input  logic                  map_we,
  input  logic [8:0]            map_addr,
  input  logic [2+RB+CB-1:0]    map_data,
  input  logic                  release_all,
  input  logic [ROWS-1:0]       row_sel_n,
  output logic [COLS-1:0]       col_n,
  output logic [ROWS*COLS-1:0]  lock_state_o,
  output logic                  evt_o
);

  localparam int EW = 2 + RB + CB;
  localparam int NK = ROWS * COLS;

  // Mapping table; contents survive reset so a core only loads it once.
  logic [EW-1:0] map_mem [512];
  logic [EW-1:0] rd_data;

  // Toggle history; primed stays low for the first sample after reset.
  logic          prev_tog;
  logic          primed;
  logic          event_s0;

  // Pipeline registers.
  logic          s1_vld;
  logic          s1_pressed;
  logic          s2_vld;
  logic          s2_pressed;
  logic [EW-1:0] s2_entry;

  // Key state, flattened row-major (bit = row*COLS+col).
  logic [NK-1:0] key_state;
  logic [NK-1:0] lock_state;
  logic [NK-1:0] matrix;

  logic [NK-1:0] hit;
  logic          apply;
  logic [COLS-1:0] col_next;

  assign event_s0 = primed && (ps2_key[10] != prev_tog);

  // Table write and event-driven read share an edge, so the read sees the old entry.
  always_ff @(posedge clk_sys) begin
    if (map_we) begin
      map_mem[map_addr] <= map_data;
    end
    rd_data <= map_mem[ps2_key[8:0]];
  end

  // Toggle history capture; first post-reset sample only primes it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_tog <= 1'b0;
      primed   <= 1'b0;
    end else begin
      prev_tog <= ps2_key[10];
      primed   <= 1'b1;
    end
  end

  // One-hot decode of the looked-up entry; no match means row/col out of range.
  always_comb begin
    hit = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (s2_entry[CB+RB-1:CB] == RB'(r) && s2_entry[CB-1:0] == CB'(c)) begin
          hit[r*COLS+c] = 1'b1;
        end
      end
    end
    apply = s2_vld && s2_entry[EW-1] && (|hit);
  end

  assign matrix = key_state | lock_state;

  // Column sense: OR of matrix bits over every selected row, active low.
  always_comb begin
    col_next = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!row_sel_n[r] && matrix[r*COLS+c]) begin
          col_next[c] = 1'b0;
        end
      end
    end
  end

  // Lookup/apply pipeline, key/lock state and registered column outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_pressed <= 1'b0;
      s2_vld     <= 1'b0;
      s2_pressed <= 1'b0;
      s2_entry   <= '0;
      key_state  <= '0;
      lock_state <= '0;
      evt_o      <= 1'b0;
      col_n      <= '1;
    end else begin
      s1_vld     <= event_s0;
      s1_pressed <= ps2_key[9];
      s2_vld     <= s1_vld;
      s2_pressed <= s1_pressed;
      s2_entry   <= rd_data;
      evt_o      <= apply;
      if (apply && !s2_entry[EW-2]) begin
        key_state <= s2_pressed ? (key_state | hit) : (key_state & ~hit);
      end
      if (apply && s2_entry[EW-2] && s2_pressed) begin
        lock_state <= lock_state ^ hit;
      end
      // release_all wins over a same-cycle momentary update.
      if (release_all) begin
        key_state <= '0;
      end
      col_n <= col_next;
    end
  end

  assign lock_state_o = lock_state;

endmodule

// File: doc/ps2_key_matrix.md
Name: ps2_key_matrix

Overview:
- Generalised PS/2 key-event to N x M scanned key-matrix emulator.
- Replaces hard-coded per-core keyboard decode in the emu top level.
- Scancode-to-matrix mapping lives in a runtime-loadable table, so one block serves any core (TI-99/4A 8x8, others).
- Supports momentary keys, toggle/lock keys (e.g. Caps → Alpha Lock), global release-all, and registered column sensing.

Parameters:
- ROWS, 8, number of matrix row strobes.
- COLS, 8, number of column sense lines.
- RB, $clog2(ROWS), row index width.
- CB, $clog2(COLS), column index width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- map_we  in  1  mapping-table write strobe.
- map_addr  in  9  table address {extended, scancode}.
- map_data  in  2+RB+CB  entry {valid, lock, row[RB-1:0], col[CB-1:0]}.
- release_all  in  1  level; clears all momentary keys (e.g. OSD open).
- row_sel_n  in  ROWS  active-low row strobes from the core.
- col_n  out  COLS  active-low column sense to the core.
- lock_state_o  out  ROWS*COLS  lock-key states, flattened row-major (bit = row*COLS+col), for LEDs.
- evt_o  out  1  one-cycle pulse when a mapped event is applied.

Behaviour:
- Reset values: col_n all 1; lock_state_o 0; evt_o 0. key_state and lock_state arrays cleared; toggle history reg cleared. Mapping table RAM contents are not reset.
- Stage 0 (event detect): event = ps2_key[10] differs from the registered previous value. On event, capture pressed and address {ps2_key[8:0]}, and issue the table read.
- Stage 1 (lookup): table is 512 x (2+RB+CB) synchronous RAM with 1-cycle read latency.
- Stage 2 (apply), taken only if entry valid=1 and row<ROWS and col<COLS:
  - lock=0: key_state[row][col] <= pressed.
  - lock=1: on pressed=1, lock_state[row][col] toggles; pressed=0 is ignored (no auto-repeat effect).
  - evt_o pulses in this cycle.
- Invalid or out-of-range entry: event dropped, no state change, no evt_o.
- Pipeline accepts one event per cycle. Back-to-back events are processed in order, each with independent 2-cycle latency from toggle edge to state update.
- Table write port has priority over nothing; write and read may coexist. Read-during-write to the same address returns OLD data: the in-flight event uses the old mapping, later events use the new one.
- release_all=1: every cycle clears all key_state bits. It overrides a stage-2 momentary update in the same cycle (result 0). lock_state is untouched; only reset clears lock_state.
- matrix[r][c] = key_state[r][c] | lock_state[r][c].
- col_n[c] registered: ~|(over r of (~row_sel_n[r] & matrix[r][c])). Latency is 1 cycle from a row_sel_n change or matrix change to col_n.
- Multiple rows selected: columns OR across selected rows; no ghost suppression.
- No rows selected: col_n all 1.
- Reset asserted mid-event: pipeline flushed; the event is lost. First ps2_key sample after reset release only initialises toggle history and generates no event.

Test Plan:
- Reset, load map 0x01C → {1,0,row5,col1} ('A'). Toggle ps2_key with pressed=1, code 0x1C. Drive row_sel_n=8'hDF → col_n=8'hFD two cycles after state update; evt_o pulses once, 2 cycles after the toggle.
- Lock key: map 0x058 → {1,1,row4,col7}. Press, release, press, release → lock_state_o bit 39 goes 1, stays 1, then 0; col_n[7] follows with row 4 selected.
- Unmapped code 0x1F7 → no evt_o; col_n stays 8'hFF for all row selects.
- Hold 'A' and lock 0x058, then pulse release_all → col_n[1] returns 1 (row 5 selected); lock bit 39 remains set. Then assert reset → lock bit 39 = 0.
- Back-to-back toggles on consecutive cycles: press 'A' then release 'A' → final key_state 0; evt_o high for 2 consecutive cycles.
- Write map 0x01C → {1,0,row0,col0} in the same cycle as an 'A' press event → event applies at (5,1). Next press applies at (0,0); row_sel_n=8'hFE gives col_n=8'hFE.
